axis_upsizer: RTL and testbench
===============================

AXIS_UPSIZER -- requirements
Module: axis_upsizer

Interface
REQ-001 The module SHALL have parameter S_TDATA_WIDTH, default 32, meaning slave tdata width in bits; it must be a multiple of 8.
REQ-002 The module SHALL have parameter RATIO, default 4, meaning slave beats packed per master beat; it must be at least 2.
REQ-003 The module SHALL derive localparam M_TDATA_WIDTH = S_TDATA_WIDTH*RATIO, default 128, meaning one AES block.
REQ-004 clk  input  1  the single clock; all logic is on posedge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 s_tvalid  input  1  slave beat valid.
REQ-007 s_tready  output  1  slave beat accepted when high with s_tvalid.
REQ-008 s_tdata  input  S_TDATA_WIDTH  slave data.
REQ-009 s_tkeep  input  S_TDATA_WIDTH/8  slave byte qualifiers.
REQ-010 s_tlast  input  1  slave packet end.
REQ-011 m_tvalid, m_tdata (M_TDATA_WIDTH), m_tkeep (M_TDATA_WIDTH/8), m_tlast  output  master stream, same semantics as the slave side.
REQ-012 m_tready  input  1  master sink ready.

Function
REQ-013 A slave transfer SHALL occur exactly when s_tvalid&&s_tready on a posedge; a master transfer SHALL occur exactly when m_tvalid&&m_tready on a posedge.
REQ-014 Packing SHALL be little-endian: the k-th accepted beat of a group (k=0..RATIO-1) SHALL land in m_tdata[k*S_TDATA_WIDTH +: S_TDATA_WIDTH], with its tkeep in the matching keep lane.
REQ-015 The module SHALL hold a lane counter, 0..RATIO-1, and an accumulator holding data and keep for lanes 0..RATIO-2.
REQ-016 The module SHALL use a two-state FSM: FILL (accumulating, m_tvalid=0 or draining) and HOLD (output register loaded, m_tvalid=1).
REQ-017 A group SHALL close on an accepted beat with lane==RATIO-1 or with s_tlast=1.
- On close: output register ← accumulator plus the current beat.
- Lanes above the closing lane SHALL have tkeep=0 and tdata=0.
- m_tlast ← s_tlast.
- lane ← 0; state → HOLD.
REQ-018 On a non-closing accepted beat, the beat SHALL be written to accumulator lane "lane", and lane SHALL increment.
REQ-019 s_tready SHALL equal !m_tvalid || m_tready, combinationally, so a closing beat is accepted on the same cycle the previous output drains.
REQ-020 This gives full throughput: sustained s_tvalid with m_tready=1 SHALL yield one master beat per RATIO slave beats, with no bubbles on the slave side.
REQ-021 Latency from the closing slave transfer to m_tvalid=1 SHALL be exactly 1 cycle.
REQ-022 The master outputs SHALL be registered and SHALL remain stable while m_tvalid=1 and m_tready=0.
REQ-023 A slave beat with s_tkeep=0 SHALL still occupy a lane, with keep zero; with s_tlast=1 it SHALL close the group normally.
REQ-024 If the close occurs on a cycle when the output drains, HOLD SHALL persist with the new contents; if the output drains with no close, the state SHALL become FILL and m_tvalid SHALL fall.
REQ-025 The accumulator SHALL be cleared on every close, so no stale keep bits leak into the next group.

Reset
REQ-026 Asserting rst_n=0 SHALL asynchronously force:
- m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0
- lane=0, accumulator cleared, state FILL.
REQ-027 Reset mid-packet SHALL discard any partial group, and the first beat after release SHALL go to lane 0.
REQ-028 s_tready SHALL be 1 while in reset and after release.

Structure
REQ-029 The shared package axis_pkg SHALL hold the FSM state typedef (FILL, HOLD) and the default width constants (32, 128).
REQ-030 The module SHALL have flat ports so it binds directly to the master/slave modports of the stream interface in benches.
REQ-031 The module SHALL have no sub-module; parameter legality SHALL be checked with elaboration-time assertions.

Verification
REQ-032 Burst test: 8 beats 0x00000000..0x00000007, tkeep=F, tlast on beat 8, m_tready=1 → master beats 0x00000003_00000002_00000001_00000000 and 0x...07_06_05_04; keep=FFFF; tlast only on the second; s_tready constantly 1.
REQ-033 Short-packet test: 3 beats A,B,C with tlast on C → one master beat 0x00000000_C_B_A, keep=0x0FFF, tlast=1, one cycle after C.
REQ-034 Backpressure test: m_tready=0 while 5 beats are offered → 4 accepted; s_tready=0 thereafter; m_tdata stable; after m_tready=1, the fifth beat is accepted that same cycle.
REQ-035 Null-beat test: beat X keep=F, then beat keep=0 with tlast=1 → keep=0x000F, tlast=1.
REQ-036 Reset test: rst_n pulsed low after 2 beats of a group → m_tvalid=0 immediately; the next 4 beats form a clean group starting at lane 0.
REQ-037 Parameter test: S_TDATA_WIDTH=8, RATIO=16, random tvalid/tready → scoreboard byte-exact match, tlast count equal.

Source files
------------

// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-Stream width converters.
//   state_e             : packer FSM state (FILL = accumulating, HOLD = output
//                         register loaded and presented on the master side)
//   AXIS_S_TDATA_WIDTH  : default narrow (slave) data width
//   AXIS_M_TDATA_WIDTH  : default wide (master) data width, one AES block
// -----------------------------------------------------------------------------
package axis_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int AXIS_S_TDATA_WIDTH = 32;
    localparam int AXIS_M_TDATA_WIDTH = 128;

endpackage

// File: rtl/axis_upsizer.sv
// -----------------------------------------------------------------------------
// axis_upsizer
// Packs RATIO narrow AXI-Stream beats into one wide beat, little-endian: the
// k-th accepted beat of a group lands in lane k of m_tdata/m_tkeep. A group
// closes on its last lane or on s_tlast; unused upper lanes are zero.
//
// Ports
//   clk       : clock, all logic on posedge
//   rst_n     : asynchronous active-low reset
//   s_tvalid  : slave beat valid
//   s_tready  : slave ready (!m_tvalid || m_tready)
//   s_tdata   : slave data, S_TDATA_WIDTH bits
//   s_tkeep   : slave byte qualifiers
//   s_tlast   : slave packet end
//   m_tvalid  : master beat valid (registered)
//   m_tready  : master sink ready
//   m_tdata   : master data, S_TDATA_WIDTH*RATIO bits (registered)
//   m_tkeep   : master byte qualifiers (registered)
//   m_tlast   : master packet end (registered)
// -----------------------------------------------------------------------------
module axis_upsizer
    import axis_pkg::*;
#(
    parameter int S_TDATA_WIDTH = AXIS_S_TDATA_WIDTH,
    parameter int RATIO         = 4,
    localparam int M_TDATA_WIDTH = S_TDATA_WIDTH * RATIO
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic [S_TDATA_WIDTH-1:0]     s_tdata,
    input  logic [S_TDATA_WIDTH/8-1:0]   s_tkeep,
    input  logic                         s_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [M_TDATA_WIDTH-1:0]     m_tdata,
    output logic [M_TDATA_WIDTH/8-1:0]   m_tkeep,
    output logic                         m_tlast
);

    localparam int SK_W   = S_TDATA_WIDTH / 8;
    localparam int MK_W   = M_TDATA_WIDTH / 8;
    localparam int ACC_W  = S_TDATA_WIDTH * (RATIO - 1);
    localparam int ACCK_W = SK_W * (RATIO - 1);
    localparam int LANE_W = $clog2(RATIO);

    if ((S_TDATA_WIDTH < 8) || (S_TDATA_WIDTH % 8 != 0)) begin : g_bad_width
        $error("axis_upsizer: S_TDATA_WIDTH must be a non-zero multiple of 8");
    end
    if (RATIO < 2) begin : g_bad_ratio
        $error("axis_upsizer: RATIO must be at least 2");
    end

    state_e              state_q,    state_d;
    logic [LANE_W-1:0]   lane_q,     lane_d;
    logic [ACC_W-1:0]    acc_data_q, acc_data_d;
    logic [ACCK_W-1:0]   acc_keep_q, acc_keep_d;
    logic [M_TDATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [MK_W-1:0]     out_keep_q, out_keep_d;
    logic                out_last_q, out_last_d;

    // Accumulator padded with an empty top lane so every lane index is legal
    // when assembling the closing beat.
    logic [M_TDATA_WIDTH-1:0] acc_data_ext;
    logic [MK_W-1:0]          acc_keep_ext;
    logic                     s_fire;
    logic                     m_fire;
    logic                     close;

    assign acc_data_ext = {{S_TDATA_WIDTH{1'b0}}, acc_data_q};
    assign acc_keep_ext = {{SK_W{1'b0}}, acc_keep_q};

    assign m_tvalid = (state_q == HOLD);
    assign s_tready = !m_tvalid || m_tready;
    assign s_fire   = s_tvalid && s_tready;
    assign m_fire   = m_tvalid && m_tready;
    assign close    = s_fire && ((lane_q == LANE_W'(RATIO - 1)) || s_tlast);

    assign m_tdata  = out_data_q;
    assign m_tkeep  = out_keep_q;
    assign m_tlast  = out_last_q;

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        acc_data_d = acc_data_q;
        acc_keep_d = acc_keep_q;
        out_data_d = out_data_q;
        out_keep_d = out_keep_q;
        out_last_d = out_last_q;

        // A drain without a close empties the output; a close below overrides.
        if (m_fire) begin
            state_d = FILL;
        end

        if (s_fire) begin
            if (close) begin
                for (int k = 0; k < RATIO; k++) begin
                    if (LANE_W'(k) < lane_q) begin
                        out_data_d[k*S_TDATA_WIDTH +: S_TDATA_WIDTH] = acc_data_ext[k*S_TDATA_WIDTH +: S_TDATA_WIDTH];
                        out_keep_d[k*SK_W +: SK_W]                   = acc_keep_ext[k*SK_W +: SK_W];
                    end else if (LANE_W'(k) == lane_q) begin
                        out_data_d[k*S_TDATA_WIDTH +: S_TDATA_WIDTH] = s_tdata;
                        out_keep_d[k*SK_W +: SK_W]                   = s_tkeep;
                    end else begin
                        out_data_d[k*S_TDATA_WIDTH +: S_TDATA_WIDTH] = '0;
                        out_keep_d[k*SK_W +: SK_W]                   = '0;
                    end
                end
                out_last_d = s_tlast;
                lane_d     = '0;
                acc_data_d = '0;
                acc_keep_d = '0;
                state_d    = HOLD;
            end else begin
                for (int k = 0; k < RATIO - 1; k++) begin
                    if (LANE_W'(k) == lane_q) begin
                        acc_data_d[k*S_TDATA_WIDTH +: S_TDATA_WIDTH] = s_tdata;
                        acc_keep_d[k*SK_W +: SK_W]                   = s_tkeep;
                    end
                end
                lane_d = lane_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            lane_q     <= '0;
            acc_data_q <= '0;
            acc_keep_q <= '0;
            out_data_q <= '0;
            out_keep_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            acc_data_q <= acc_data_d;
            acc_keep_q <= acc_keep_d;
            out_data_q <= out_data_d;
            out_keep_q <= out_keep_d;
            out_last_q <= out_last_d;
        end
    end

endmodule

// File: tb/tb_axis_upsizer.sv
// -----------------------------------------------------------------------------
// tb_axis_upsizer
// Two instances: 32-bit x4 (directed + random) and 8-bit x16 (random).
// A queue-based packing model predicts every master beat; a negedge process
// compares DUT outputs with it each cycle. Directed literals pin the model.
// -----------------------------------------------------------------------------
module tb_axis_upsizer;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    logic clk;
    logic rst_n;

    logic         s0_tvalid, s0_tready, s0_tlast;
    logic [31:0]  s0_tdata;
    logic [3:0]   s0_tkeep;
    logic         m0_tvalid, m0_tready, m0_tlast;
    logic [127:0] m0_tdata;
    logic [15:0]  m0_tkeep;

    logic         s1_tvalid, s1_tready, s1_tlast;
    logic [7:0]   s1_tdata;
    logic [0:0]   s1_tkeep;
    logic         m1_tvalid, m1_tready, m1_tlast;
    logic [127:0] m1_tdata;
    logic [15:0]  m1_tkeep;

    int nvec = 0;
    int nerr = 0;

    beat_t q0[$];
    beat_t q1[$];
    beat_t log0[$];
    logic [127:0] gd[2];
    logic [15:0]  gk[2];
    int           gn[2];
    int           slast1, mlast1;
    logic         burst_win, burst_drop;
    logic         done0, done1;

    axis_upsizer #(.S_TDATA_WIDTH(32), .RATIO(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid(s0_tvalid), .s_tready(s0_tready), .s_tdata(s0_tdata),
        .s_tkeep(s0_tkeep), .s_tlast(s0_tlast),
        .m_tvalid(m0_tvalid), .m_tready(m0_tready), .m_tdata(m0_tdata),
        .m_tkeep(m0_tkeep), .m_tlast(m0_tlast)
    );

    axis_upsizer #(.S_TDATA_WIDTH(8), .RATIO(16)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid(s1_tvalid), .s_tready(s1_tready), .s_tdata(s1_tdata),
        .s_tkeep(s1_tkeep), .s_tlast(s1_tlast),
        .m_tvalid(m1_tvalid), .m_tready(m1_tready), .m_tdata(m1_tdata),
        .m_tkeep(m1_tkeep), .m_tlast(m1_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int qsize(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    // Reference: accepted slave beats are concatenated little-endian into a
    // group; a group is emitted when it holds RATIO beats or sees tlast.
    task automatic step(input int u, input int ratio, input int sw,
                        input logic sv, input logic sr, input logic [31:0] sd,
                        input logic [3:0] sk, input logic sl,
                        input logic mv, input logic mr, input logic [127:0] md,
                        input logic [15:0] mk, input logic ml);
        beat_t f;
        beat_t nb;
        int    n;
        if (!rst_n) begin
            chk($sformatf("u%0d_rst_tvalid", u), mv, 0);
            chk($sformatf("u%0d_rst_tdata", u), md, 0);
            chk($sformatf("u%0d_rst_tkeep", u), mk, 0);
            chk($sformatf("u%0d_rst_tlast", u), ml, 0);
            chk($sformatf("u%0d_rst_sready", u), sr, 1);
            if (u == 0) q0.delete(); else q1.delete();
            gd[u] = '0; gk[u] = '0; gn[u] = 0;
            return;
        end
        chk($sformatf("u%0d_sready_rule", u), sr, (!mv || mr));
        n = qsize(u);
        chk($sformatf("u%0d_tvalid", u), mv, (n != 0));
        if (n != 0) begin
            f = (u == 0) ? q0[0] : q1[0];
            chk($sformatf("u%0d_tdata", u), md, f.d);
            chk($sformatf("u%0d_tkeep", u), mk, f.k);
            chk($sformatf("u%0d_tlast", u), ml, f.l);
            if (mv && mr) begin
                if (u == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end
        if (sv && sr) begin
            gd[u] = gd[u] | (128'(sd) << (gn[u] * sw));
            gk[u] = gk[u] | (16'(sk) << (gn[u] * (sw / 8)));
            gn[u]++;
            if (gn[u] == ratio || sl) begin
                nb.d = gd[u]; nb.k = gk[u]; nb.l = sl;
                if (u == 0) q0.push_back(nb); else q1.push_back(nb);
                gd[u] = '0; gk[u] = '0; gn[u] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        step(0, 4, 32, s0_tvalid, s0_tready, s0_tdata, s0_tkeep, s0_tlast,
             m0_tvalid, m0_tready, m0_tdata, m0_tkeep, m0_tlast);
        step(1, 16, 8, s1_tvalid, s1_tready, {24'h0, s1_tdata}, {3'b0, s1_tkeep}, s1_tlast,
             m1_tvalid, m1_tready, m1_tdata, m1_tkeep, m1_tlast);
        if (rst_n) begin
            if (m0_tvalid && m0_tready) log0.push_back({m0_tdata, m0_tkeep, m0_tlast});
            if (burst_win && !s0_tready) burst_drop = 1'b1;
            if (s1_tvalid && s1_tready && s1_tlast) slast1++;
            if (m1_tvalid && m1_tready && m1_tlast) mlast1++;
        end
    end

    task automatic send0(input logic [31:0] d, input logic [3:0] k, input logic l);
        int   n;
        logic acc;
        s0_tvalid = 1'b1; s0_tdata = d; s0_tkeep = k; s0_tlast = l;
        n = 0;
        do begin
            @(negedge clk); acc = s0_tready;
            @(posedge clk); n++;
        end while (!acc && n < 200);
        if (!acc) chk("send0_timeout", 0, 1);
        #1 s0_tvalid = 1'b0; s0_tlast = 1'b0;
    endtask

    task automatic send1(input logic [7:0] d, input logic k, input logic l);
        int   n;
        logic acc;
        s1_tvalid = 1'b1; s1_tdata = d; s1_tkeep = k; s1_tlast = l;
        n = 0;
        do begin
            @(negedge clk); acc = s1_tready;
            @(posedge clk); n++;
        end while (!acc && n < 200);
        if (!acc) chk("send1_timeout", 0, 1);
        #1 s1_tvalid = 1'b0; s1_tlast = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        nerr++;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        rst_n = 1'b1;
        s0_tvalid = 0; s0_tdata = 0; s0_tkeep = 0; s0_tlast = 0; m0_tready = 1;
        s1_tvalid = 0; s1_tdata = 0; s1_tkeep = 0; s1_tlast = 0; m1_tready = 1;
        gd[0] = 0; gd[1] = 0; gk[0] = 0; gk[1] = 0; gn[0] = 0; gn[1] = 0;
        slast1 = 0; mlast1 = 0; burst_win = 0; burst_drop = 0; done0 = 0; done1 = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_tvalid", m0_tvalid, 0);
        chk("reset_sready", s0_tready, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Burst of eight beats at full rate
        log0.delete();
        burst_win = 1'b1;
        for (int i = 0; i < 8; i++) send0(32'(i), 4'hF, (i == 7));
        burst_win = 1'b0;
        repeat (3) tick();
        chk("burst_count", log0.size(), 2);
        if (log0.size() >= 2) begin
            chk("burst_beat0_data", log0[0].d, 128'h00000003_00000002_00000001_00000000);
            chk("burst_beat0_keep", log0[0].k, 16'hFFFF);
            chk("burst_beat0_last", log0[0].l, 0);
            chk("burst_beat1_data", log0[1].d, 128'h00000007_00000006_00000005_00000004);
            chk("burst_beat1_last", log0[1].l, 1);
        end
        chk("burst_no_bubble", burst_drop, 0);

        // Short packet closed by tlast
        send0(32'hAAAAAAAA, 4'hF, 0);
        send0(32'hBBBBBBBB, 4'hF, 0);
        send0(32'hCCCCCCCC, 4'hF, 1);
        chk("short_valid", m0_tvalid, 1);
        chk("short_data", m0_tdata, 128'h00000000_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        chk("short_keep", m0_tkeep, 16'h0FFF);
        chk("short_last", m0_tlast, 1);
        tick();

        // Backpressure
        m0_tready = 1'b0;
        for (int i = 0; i < 4; i++) send0(32'h11 + 32'(i), 4'hF, 0);
        s0_tvalid = 1'b1; s0_tdata = 32'h15; s0_tkeep = 4'hF; s0_tlast = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_sready_low", s0_tready, 0);
            chk("bp_valid", m0_tvalid, 1);
            chk("bp_data_stable", m0_tdata, 128'h00000014_00000013_00000012_00000011);
        end
        m0_tready = 1'b1;
        #1 chk("bp_accept_same_cycle", s0_tready, 1);
        @(posedge clk);
        #1 s0_tvalid = 1'b0;
        send0(32'h16, 4'hF, 0);
        send0(32'h17, 4'hF, 0);
        send0(32'h18, 4'hF, 1);
        chk("bp_next_data", m0_tdata, 128'h00000018_00000017_00000016_00000015);
        chk("bp_next_last", m0_tlast, 1);
        tick();

        // Null beat closing a packet
        send0(32'h12345678, 4'hF, 0);
        send0(32'h0, 4'h0, 1);
        chk("null_keep", m0_tkeep, 16'h000F);
        chk("null_last", m0_tlast, 1);
        chk("null_data", m0_tdata, 128'h12345678);
        tick();

        // Reset in the middle of a group
        send0(32'h31, 4'hF, 0);
        send0(32'h32, 4'hF, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", m0_tvalid, 0);
        chk("midrst_data", m0_tdata, 0);
        chk("midrst_sready", s0_tready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send0(32'h21 + 32'(i), 4'hF, 0);
        chk("postrst_valid", m0_tvalid, 1);
        chk("postrst_data", m0_tdata, 128'h00000024_00000023_00000022_00000021);
        chk("postrst_keep", m0_tkeep, 16'hFFFF);
        chk("postrst_last", m0_tlast, 0);
        tick();

        // Random traffic on both instances
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send0($urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0) || (i == 299));
                end
                done0 = 1'b1;
            end
            begin
                while (!done0) begin
                    tick();
                    m0_tready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int i = 0; i < 400; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send1(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) || (i == 399));
                end
                done1 = 1'b1;
            end
            begin
                while (!done1) begin
                    tick();
                    m1_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        m0_tready = 1'b1;
        m1_tready = 1'b1;
        repeat (20) tick();
        chk("u0_drained", q0.size(), 0);
        chk("u1_drained", q1.size(), 0);
        chk("u1_tlast_count", mlast1, slast1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
